// File: rtl/im_loader.sv
// im_loader: packs a framed byte stream into 32-bit words, writes instruction memory, holds the CPU in reset until done.
// Optional trailing XOR checksum byte is enabled by defining IM_LOADER_CSUM_EN.
module im_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [15:0]       words_loaded,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_rst_f
);
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DATA, CSUM, DONE, ERR} state_t;
`ifdef IM_LOADER_CSUM_EN
    localparam state_t END_ST = CSUM;
`else
    localparam state_t END_ST = DONE;
`endif
    state_t      state, state_nx;
    logic [7:0]  cnt_hi, csum;
    logic [15:0] n, n_nx, w_idx;
    logic [1:0]  b_idx;
    logic [23:0] part;
    logic        xfer, last_word, rearm;

    assign xfer      = in_valid && in_ready;
    assign n_nx      = {cnt_hi, in_data};
    assign last_word = w_idx == n - 16'd1;
    assign rearm     = restart && (state == DONE || state == ERR);

    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) state <= CNT_HI;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            CNT_HI:  if (xfer) state_nx = CNT_LO;
            CNT_LO:  if (xfer) state_nx = 32'(n_nx) > 32'(MAX_WORDS) ? ERR : n_nx == 16'd0 ? END_ST : DATA;
            DATA:    if (xfer && b_idx == 2'd3 && last_word) state_nx = END_ST;
            CSUM:    if (xfer) state_nx = in_data == csum ? DONE : ERR;
            default: if (restart) state_nx = CNT_HI;
        endcase
    end

    always_comb begin
        in_ready  = state == CNT_HI || state == CNT_LO || state == DATA || state == CSUM;
        load_done = state == DONE;
        load_err  = state == ERR;
    end

    // Writes are registered, so the byte stream never needs backpressure.
    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) begin
            wr_en        <= 1'b0;
            wr_addr      <= BASE_ADDR;
            wr_data      <= '0;
            words_loaded <= '0;
            cpu_rst_f    <= 1'b0;
            cnt_hi       <= '0;
            csum         <= '0;
            n            <= '0;
            w_idx        <= '0;
            b_idx        <= '0;
            part         <= '0;
        end else begin
            wr_en     <= xfer && state == DATA && b_idx == 2'd3;
            cpu_rst_f <= state == DONE && !restart;
            if (wr_en) words_loaded <= words_loaded + 16'd1;
            if (xfer)
                case (state)
                    CNT_HI: cnt_hi <= in_data;
                    CNT_LO: begin
                        n     <= n_nx;
                        w_idx <= '0;
                        b_idx <= '0;
                    end
                    DATA: begin
                        csum  <= csum ^ in_data;
                        b_idx <= b_idx + 2'd1;
                        part  <= {part[15:0], in_data};
                        if (b_idx == 2'd3) begin
                            wr_data <= {part, in_data};
                            wr_addr <= BASE_ADDR + ADDR_W'(w_idx);
                            w_idx   <= w_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            if (rearm) begin
                words_loaded <= '0;
                csum         <= '0;
                w_idx        <= '0;
                b_idx        <= '0;
            end
        end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: scoreboard bench for im_loader; adapts to IM_LOADER_CSUM_EN.
module tb_im_loader;
    logic        clk = 0, rst_f = 0, restart = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, wr_en, load_done, load_err, cpu_rst_f;
    logic [15:0] wr_addr, words_loaded;
    logic [31:0] wr_data;
    int          checks = 0, failures = 0, cyc = 0, n_wr = 0, prev_wr = 0, last_wr = 0;
    logic [47:0] exp_q[$];
    logic [31:0] img[4];

    im_loader dut (
        .clk(clk), .rst_f(rst_f), .restart(restart), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .words_loaded(words_loaded), .load_done(load_done), .load_err(load_err), .cpu_rst_f(cpu_rst_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        logic [47:0] e;
        if (wr_en) begin
            checks++;
            n_wr++;
            prev_wr = last_wr;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected got addr=%h data=%h want no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    failures++;
                    $display("FAIL wr_scoreboard got addr=%h data=%h want addr=%h data=%h", wr_addr, wr_data, e[47:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1;
        in_data  = b;
        @(posedge clk);
    endtask

    task automatic idle;
        @(negedge clk);
        in_valid = 0;
        in_data  = 8'hff;
        @(posedge clk);
    endtask

    function automatic logic [7:0] xsum(input int nw);
        logic [7:0] x = 0;
        for (int w = 0; w < nw; w++) x ^= img[w][31:24] ^ img[w][23:16] ^ img[w][15:8] ^ img[w][7:0];
        return x;
    endfunction

    task automatic send_frame(input int nw, input logic [7:0] cs, input bit gaps);
        put(8'(nw >> 8));
        put(8'(nw));
        for (int w = 0; w < nw; w++)
            for (int b = 0; b < 4; b++) begin
                if (gaps) idle;
                if (b == 3) exp_q.push_back({16'(w), img[w]});
                put(img[w][31-8*b -: 8]);
                if (b == 3) begin
                    #1;
                    checks++;
                    if (wr_en !== 1'b1) begin
                        failures++;
                        $display("FAIL wr_latency word=%0d got wr_en=%b want 1", w, wr_en);
                    end
                end
            end
`ifdef IM_LOADER_CSUM_EN
        if (gaps) idle;
        put(cs);
`else
        if (gaps && cs == 8'h00) idle;
`endif
        #1;
    endtask

    task automatic do_restart;
        @(negedge clk);
        in_valid = 0;
        restart  = 1;
        @(posedge clk);
        #1;
        restart = 0;
        checks++;
        if ({in_ready, load_done, load_err, cpu_rst_f, words_loaded} !== {4'b1000, 16'd0}) begin
            failures++;
            $display("FAIL restart got rdy/done/err/cpu=%b%b%b%b words=%0d want 1000 words=0", in_ready, load_done, load_err, cpu_rst_f, words_loaded);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, words_loaded, load_done, load_err, cpu_rst_f} !== {2'b10, 16'h0, 32'h0, 16'h0, 3'b000}) begin
            failures++;
            $display("FAIL reset_values got rdy=%b wr=%b addr=%h data=%h words=%0d done=%b err=%b cpu=%b", in_ready, wr_en, wr_addr, wr_data, words_loaded, load_done, load_err, cpu_rst_f);
        end
        @(negedge clk);
        rst_f = 1;
    endtask

    task automatic test_full;
        int n0;
        img[0] = 32'h10000001;
        img[1] = 32'h20000002;
        send_frame(2, xsum(2), 0);
        checks++;
        if ({load_done, load_err, cpu_rst_f} !== 3'b100) begin
            failures++;
            $display("FAIL full_done got done/err/cpu=%b%b%b want 100", load_done, load_err, cpu_rst_f);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({cpu_rst_f, words_loaded, exp_q.size() == 0} !== {1'b1, 16'd2, 1'b1}) begin
            failures++;
            $display("FAIL full_release got cpu=%b words=%0d pending=%0d want cpu=1 words=2 pending=0", cpu_rst_f, words_loaded, exp_q.size());
        end
        checks++;
        if (last_wr - prev_wr !== 4) begin
            failures++;
            $display("FAIL full_rate_spacing got %0d want 4", last_wr - prev_wr);
        end
        n0 = n_wr;
        repeat (3) put(8'h55);
        #1;
        checks++;
        if ({load_done, in_ready, words_loaded, n_wr == n0} !== {2'b10, 16'd2, 1'b1}) begin
            failures++;
            $display("FAIL done_ignores_input got done=%b rdy=%b words=%0d writes=%0d want done=1 rdy=0 words=2 writes=%0d", load_done, in_ready, words_loaded, n_wr, n0);
        end
    endtask

    task automatic test_csum_bad;
`ifdef IM_LOADER_CSUM_EN
        int n0;
        n0 = n_wr;
        send_frame(2, xsum(2) ^ 8'h01, 0);
        checks++;
        if ({load_done, load_err, n_wr - n0} !== {2'b01, 32'd2}) begin
            failures++;
            $display("FAIL csum_bad got done=%b err=%b writes=%0d want done=0 err=1 writes=2", load_done, load_err, n_wr - n0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cpu_rst_f !== 1'b0) begin
            failures++;
            $display("FAIL csum_bad_cpu got %b want 0", cpu_rst_f);
        end
        do_restart;
`endif
    endtask

    task automatic test_oversize;
        int n0;
        n0 = n_wr;
        put(8'h04);
        put(8'h01);
        #1;
        checks++;
        if ({load_err, load_done, in_ready, wr_en} !== 4'b1000) begin
            failures++;
            $display("FAIL oversize got err/done/rdy/wr=%b%b%b%b want 1000", load_err, load_done, in_ready, wr_en);
        end
        repeat (6) put(8'h11);
        #1;
        checks++;
        if ({load_err, n_wr == n0, cpu_rst_f} !== 3'b110) begin
            failures++;
            $display("FAIL oversize_hold got err=%b writes=%0d cpu=%b want err=1 writes=%0d cpu=0", load_err, n_wr, cpu_rst_f, n0);
        end
    endtask

    task automatic test_zero;
        int n0;
        n0 = n_wr;
        put(8'h00);
        put(8'h00);
`ifdef IM_LOADER_CSUM_EN
        put(8'h00);
`endif
        #1;
        checks++;
        if ({load_done, load_err, n_wr == n0} !== 3'b101) begin
            failures++;
            $display("FAIL zero_count got done=%b err=%b writes=%0d want done=1 err=0 writes=%0d", load_done, load_err, n_wr, n0);
        end
    endtask

    task automatic test_gaps;
        img[0] = 32'hA1B2C3D4;
        send_frame(1, xsum(1), 1);
        @(posedge clk);
        #1;
        checks++;
        if ({load_done, words_loaded, exp_q.size() == 0, cpu_rst_f} !== {1'b1, 16'd1, 2'b11}) begin
            failures++;
            $display("FAIL gaps got done=%b words=%0d pending=%0d cpu=%b want done=1 words=1 pending=0 cpu=1", load_done, words_loaded, exp_q.size(), cpu_rst_f);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        put(8'h00);
        put(8'h01);
        put(8'hde);
        put(8'had);
        @(negedge clk);
        in_valid = 0;
        rst_f    = 0;
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, words_loaded, load_done, load_err, cpu_rst_f} !== {2'b10, 16'h0, 32'h0, 16'h0, 3'b000}) begin
            failures++;
            $display("FAIL mid_reset_values got rdy=%b wr=%b addr=%h data=%h words=%0d done=%b err=%b cpu=%b", in_ready, wr_en, wr_addr, wr_data, words_loaded, load_done, load_err, cpu_rst_f);
        end
        @(negedge clk);
        rst_f = 1;
        n0 = n_wr;
        img[0] = 32'hCAFEF00D;
        send_frame(1, xsum(1), 0);
        @(posedge clk);
        #1;
        checks++;
        if ({load_done, cpu_rst_f, n_wr - n0, exp_q.size() == 0} !== {2'b11, 32'd1, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset_reload got done=%b cpu=%b writes=%0d pending=%0d want done=1 cpu=1 writes=1 pending=0", load_done, cpu_rst_f, n_wr - n0, exp_q.size());
        end
        do_restart;
    endtask

    initial begin
        test_reset;
        test_full;
        do_restart;
        test_csum_bad;
        test_oversize;
        do_restart;
        test_zero;
        do_restart;
        test_gaps;
        do_restart;
        test_reset_mid;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader for the SISC processor: the writing end of the instruction-memory interface that the processor fetch path only reads. It accepts a framed byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words and writes them into instruction memory. It holds the processor in reset until a complete, valid image has been loaded.

## Interface
- ADDR_W, 16: instruction-memory word-address width.
- BASE_ADDR, 16'h0000: address that receives the first loaded word.
- MAX_WORDS, 1024: largest accepted word count.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_f  in  1  reset. One clock; reset is asynchronous and active-low.
- restart  in  1  synchronous pulse that re-arms the loader from DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  instruction-memory word address.
- wr_data  out  32  instruction word.
- words_loaded  out  16  count of words written since arm.
- load_done  out  1  image accepted.
- load_err  out  1  image rejected.
- cpu_rst_f  out  1  active-low reset to the processor. Released only when load_done=1 and load_err=0.

## Operation
- Frame format:
  - count high byte, then count low byte (N words, big-endian).
  - N×4 payload bytes, each word big-endian (first byte becomes wr_data[31:24]).
  - one checksum byte, only when checksum support is compiled in.
- A byte is transferred on each cycle where in_valid=1 and in_ready=1. No other cycle advances state.
- States:
  - CNT_HI: accept a byte, go to CNT_LO.
  - CNT_LO: accept a byte and form N.
    - N > MAX_WORDS goes to ERR.
    - N = 0 goes to CSUM, or to DONE if checksum support is compiled out.
    - Otherwise go to DATA.
  - DATA: a 2-bit byte index packs bytes. On the 4th byte, register the word for writing.
    - After the last byte of word N-1, go to CSUM, or to DONE if checksum support is compiled out.
  - CSUM: accept one byte. If it equals the running XOR, go to DONE; otherwise go to ERR.
  - DONE: load_done=1, in_ready=0.
  - ERR: load_err=1, in_ready=0.
- in_ready=1 in CNT_HI, CNT_LO, DATA and CSUM. No backpressure is needed, because writes are registered.
- wr_addr = BASE_ADDR + word index, truncated to ADDR_W (wraps silently).
- words_loaded increments on every wr_en pulse.
- restart asserted in DONE or ERR:
  - go to CNT_HI;
  - clear words_loaded, checksum, load_done and load_err;
  - drive cpu_rst_f low.
- restart in any other state is ignored.
- Memory contents are never cleared by the loader.

## Timing
- Reset values: state=CNT_HI, in_ready=1 (combinational from state), wr_en=0, wr_addr=BASE_ADDR, wr_data=0, words_loaded=0, load_done=0, load_err=0, cpu_rst_f=0.
- Write latency: wr_en is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. wr_addr and wr_data are valid in that same cycle.
- load_done and load_err rise the cycle after the final accepted byte.
- cpu_rst_f rises one cycle after load_done rises, through its own register, so the last write has completed before the processor fetches.
- Back-to-back bytes every cycle are supported at full rate. Consecutive wr_en pulses are then 4 cycles apart.
- The ERR decision for an oversized count is made on the CNT_LO byte. No payload bytes are written.
- Reset asserted mid-frame:
  - immediately return to reset values;
  - any partial word is discarded;
  - a write already issued has completed.
- in_valid during DONE or ERR is ignored; nothing is consumed.

## Configuration
- IM_LOADER_CSUM_EN defined:
  - the CSUM state exists;
  - a running XOR of all payload bytes (count bytes excluded) is compared with the trailing byte;
  - a mismatch goes to ERR.
- Undefined:
  - there is no checksum byte;
  - the last payload byte leads directly to DONE;
  - ERR is reachable only through an oversized count.

## Test plan
- Count 0x0002, bytes 10 00 00 01 20 00 00 02, csum 0x33 -> wr_en pulses: addr 0x0000 data 0x10000001, then addr 0x0001 data 0x20000002. words_loaded=2, load_done=1, cpu_rst_f=1 one cycle later.
- Same frame, csum 0x34 -> both writes occur, load_err=1, load_done=0, cpu_rst_f stays 0.
- Count 0x0401 with MAX_WORDS=1024 -> load_err the cycle after the low byte, no wr_en, in_ready=0.
- Count 0x0000, csum 0x00 -> load_done with no writes; with IM_LOADER_CSUM_EN undefined, load_done follows the low byte.
- in_valid toggling 1/0 every cycle through a 1-word frame -> identical write data and address to the full-rate case; only bytes with in_valid=1 are counted.
- rst_f pulled low after 2 payload bytes, then released, then a full 1-word frame -> outputs at reset values during reset; exactly one write of the new word to 0x0000; then a restart pulse from DONE returns to CNT_HI with cpu_rst_f=0.
